// File: rtl/micro_sequencer.sv
// Microstep sequencer: alternates the NXI fetch microprogram with the latched opcode's
// microprogram, stalls on WAIT_* handshakes, and halts on HLT_CLK.
package micro_sequencer_pkg;
  typedef enum logic [4:0] {
    NXI, ATB, GPU, WFT, WMT, WUT, WDD, HLT, LDA, CPY
  } Opcode_enum;

  typedef enum logic [4:0] {
    NOP, ENDMICRO, HLT_CLK, WAIT_GPU, WAIT_MT, WAIT_UT, WAIT_FT, WAIT_DD,
    START_GPU, RAM_to_IR, PC_to_MAR, PC_INC, A_to_B, RAM_to_A, MAR_LOAD
  } Microcode_enum;
endpackage

module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int CYCLE_W   = 6,
  parameter int MAX_CYCLE = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  Microcode_enum      ucode,
  input  Opcode_enum         ir_opcode,
  input  logic               gpu_busy,
  input  logic               ms_busy,
  input  logic               us_busy,
  input  logic               frame_tick,
  input  logic               bcd_busy,
  output Opcode_enum         operation,
  output logic [CYCLE_W-1:0] cycle,
  output logic               ucode_en,
  output logic               instr_done,
  output logic               halted,
  output logic               overrun
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  localparam logic [CYCLE_W-1:0] LAST = CYCLE_W'(MAX_CYCLE);

  state_t             state, state_nxt;
  Opcode_enum         op_nxt;
  logic [CYCLE_W-1:0] cycle_nxt;
  logic               done_nxt, overrun_nxt;
  logic               stall, active;

  always_comb begin
    stall = 1'b0;
    case (ucode)
      WAIT_GPU: stall = gpu_busy;
      WAIT_MT:  stall = ms_busy;
      WAIT_UT:  stall = us_busy;
      WAIT_FT:  stall = !frame_tick;
      WAIT_DD:  stall = bcd_busy;
      default:  stall = 1'b0;
    endcase
  end

  assign active   = run && (state != HALT);
  // ENDMICRO only moves the sequencer; it never strobes the datapath.
  assign ucode_en = active && !stall && (ucode != ENDMICRO);
  assign halted   = (state == HALT);

  always_comb begin
    state_nxt   = state;
    op_nxt      = operation;
    cycle_nxt   = cycle;
    done_nxt    = 1'b0;
    overrun_nxt = overrun;
    if (active && !stall) begin
      if (ucode == ENDMICRO) begin
        cycle_nxt = '0;
        if (state == FETCH) begin
          state_nxt = EXEC;
          op_nxt    = ir_opcode;
        end else begin
          state_nxt = FETCH;
          op_nxt    = NXI;
          done_nxt  = 1'b1;
        end
      end else if (ucode == HLT_CLK) begin
        state_nxt = HALT;
      end else if (cycle == LAST) begin
        // Runaway microprogram: abandon it and refetch rather than wrap.
        overrun_nxt = 1'b1;
        state_nxt   = FETCH;
        op_nxt      = NXI;
        cycle_nxt   = '0;
      end else begin
        cycle_nxt = cycle + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      operation  <= NXI;
      cycle      <= '0;
      instr_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      operation  <= op_nxt;
      cycle      <= cycle_nxt;
      instr_done <= done_nxt;
      overrun    <= overrun_nxt;
    end
  end
endmodule
